// File: rtl/bcd_decade_counter_if.sv
// bcd_decade_counter_if: control/status bundle for the BCD decade counter
//   master drives: en, up, load, load_val[4*DIGITS-1:0]
//   slave drives:  count[4*DIGITS-1:0], tc, wrap, load_err
interface bcd_decade_counter_if #(parameter int DIGITS = 2);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  wrap;
  logic                  load_err;
  modport master(output en, up, load, load_val, input count, tc, wrap, load_err);
  modport slave(input en, up, load, load_val, output count, tc, wrap, load_err);
endinterface

// File: rtl/bcd_decade_counter.sv
// bcd_decade_counter: multi-digit BCD up/down counter with validated parallel load
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : slave modport of bcd_decade_counter_if
//     en/up      count enable / direction (1 = up)
//     load       parallel load of load_val, rejected if any digit > 9
//     count      registered value, digit i at [4i+3:4i]
//     tc         combinational terminal count (cascade enable)
//     wrap       one-cycle pulse after a modulo wrap
//     load_err   one-cycle pulse after a rejected load
//   BCD_SAT_EN : when defined, the counter saturates at the limits and wrap stays 0
module bcd_decade_counter #(parameter int DIGITS = 2) (
  input  logic clk,
  input  logic rst_n,
  bcd_decade_counter_if.slave bus
);
  logic [4*DIGITS-1:0] count_q, count_d, step;
  logic [DIGITS:0]     c;
  logic [DIGITS-1:0]   nine, zero, bad;
  logic                wrap_q, wrap_d, err_q, err_d, lim;
  // c[g] is the carry (up) or borrow (down) into digit g; digit 0 always steps
  assign c[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] dig;
    assign dig     = count_q[4*g +: 4];
    assign nine[g] = dig == 4'd9;
    assign zero[g] = dig == 4'd0;
    assign bad[g]  = bus.load_val[4*g +: 4] > 4'd9;
    assign c[g+1]  = c[g] & (bus.up ? nine[g] : zero[g]);
    assign step[4*g +: 4] = !c[g] ? dig :
                            bus.up ? (nine[g] ? 4'd0 : dig + 4'd1) :
                                     (zero[g] ? 4'd9 : dig - 4'd1);
  end
  assign lim = bus.up ? &nine : &zero;
  always_comb begin
`ifdef BCD_SAT_EN
    count_d = bus.load ? (|bad ? count_q : bus.load_val) :
              bus.en   ? (lim ? count_q : step) : count_q;
    wrap_d  = 1'b0;
`else
    count_d = bus.load ? (|bad ? count_q : bus.load_val) :
              bus.en   ? step : count_q;
    wrap_d  = bus.tc;
`endif
    err_d   = bus.load & |bad;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  assign bus.tc       = bus.en & lim & !bus.load;
  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;
endmodule
